// File: rtl/id_ex_if.sv
// id_ex_if: ID-to-EX pipeline bundle (decode inputs, EX outputs, hazard controls); ID_EX_PERF_CNT_EN adds stall/flush counters
interface id_ex_if #(parameter int DW = 8);
  logic stall;
  logic flush;
  logic valid_id;
  logic [1:0] ra_id;
  logic [1:0] rb_id;
  logic [7:0] ctrl_id;
  logic [DW-1:0] opa_id;
  logic [DW-1:0] opb_id;
  logic [DW-1:0] imm_id;
  logic valid_ex;
  logic [1:0] ra_ex;
  logic [1:0] rb_ex;
  logic [7:0] ctrl_ex;
  logic [DW-1:0] opa_ex;
  logic [DW-1:0] opb_ex;
  logic [DW-1:0] imm_ex;
  logic hold_front;
  logic bubble_mem;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif
  modport master (
    output stall, flush, valid_id, ra_id, rb_id, ctrl_id, opa_id, opb_id, imm_id,
    input valid_ex, ra_ex, rb_ex, ctrl_ex, opa_ex, opb_ex, imm_ex, hold_front, bubble_mem
`ifdef ID_EX_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );
  modport slave (
    input stall, flush, valid_id, ra_id, rb_id, ctrl_id, opa_id, opb_id, imm_id,
    output valid_ex, ra_ex, rb_ex, ctrl_ex, opa_ex, opb_ex, imm_ex, hold_front, bubble_mem
`ifdef ID_EX_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with load-use stall, branch flush and bubble insertion; ID_EX_PERF_CNT_EN adds saturating stall/flush counters
module id_ex_reg #(parameter int DW = 8) (
  input logic clk,
  input logic rst,
  id_ex_if.slave bus
);
  logic valid_q, valid_d;
  logic [1:0] ra_q, ra_d, rb_q, rb_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d, imm_q, imm_d;
  logic keep;
  assign keep = bus.stall | bus.flush;
  // next EX state: flush kills controls, stall holds, otherwise capture (invalid slots carry zero controls)
  always_comb begin
    valid_d = bus.flush ? 1'b0 : bus.stall ? valid_q : bus.valid_id;
    ctrl_d = bus.flush ? 8'h00 : bus.stall ? ctrl_q : (bus.valid_id ? bus.ctrl_id : 8'h00);
    ra_d = keep ? ra_q : bus.ra_id;
    rb_d = keep ? rb_q : bus.rb_id;
    opa_d = keep ? opa_q : bus.opa_id;
    opb_d = keep ? opb_q : bus.opb_id;
    imm_d = keep ? imm_q : bus.imm_id;
  end
  // EX-stage registers, reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ra_q <= '0;
      rb_q <= '0;
      ctrl_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
      imm_q <= '0;
    end else begin
      valid_q <= valid_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      ctrl_q <= ctrl_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      imm_q <= imm_d;
    end
  end
  assign bus.valid_ex = valid_q;
  assign bus.ra_ex = ra_q;
  assign bus.rb_ex = rb_q;
  assign bus.ctrl_ex = ctrl_q;
  assign bus.opa_ex = opa_q;
  assign bus.opb_ex = opb_q;
  assign bus.imm_ex = imm_q;
  assign bus.hold_front = bus.stall & ~bus.flush;
  assign bus.bubble_mem = bus.stall | ~valid_q;
`ifdef ID_EX_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  // saturating event counters
  always_comb begin
    stall_cnt_d = (bus.stall & ~bus.flush & ~&stall_cnt_q) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    flush_cnt_d = (bus.flush & ~&flush_cnt_q) ? flush_cnt_q + 16'd1 : flush_cnt_q;
  end
  // counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif
endmodule
